// File: rtl/tea_decrypt.sv
// TEA block decryptor with bit-serial load and unload.
// Ports:
//   i_clk, i_rst_n  - clock and asynchronous active-low reset
//   i_key_update    - in IDLE, shift i_rx into the 128-bit key (MSB first)
//   i_data_shift    - in IDLE, shift i_rx into the 64-bit ciphertext (MSB first)
//   i_calculate     - start decryption (wins over both shift controls)
//   i_rx            - serial input bit
//   o_tx            - serial plaintext bit, MSB first
//   o_tx_valid      - o_tx carries a plaintext bit this cycle
//   o_ready         - block is idle and accepting key, data and start
module tea_decrypt (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_update,
  input  logic i_data_shift,
  input  logic i_calculate,
  input  logic i_rx,
  output logic o_tx,
  output logic o_tx_valid,
  output logic o_ready
);

  localparam int unsigned KEY_W   = 128;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 5;
  localparam int unsigned BIT_W   = 6;

  localparam logic [WORD_W-1:0]  DELTA      = 32'h9E37_79B9;
  localparam logic [WORD_W-1:0]  SUM_INIT   = 32'hC6EF_3720;
  localparam logic [ROUND_W-1:0] LAST_ROUND = 5'd31;
  localparam logic [BIT_W-1:0]   LAST_BIT   = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t              state;
  logic [KEY_W-1:0]    key;
  logic [DATA_W-1:0]   data;
  logic [WORD_W-1:0]   sum;
  logic [ROUND_W-1:0]  round_cnt;
  logic [BIT_W-1:0]    bit_cnt;

  logic [WORD_W-1:0] k0, k1, k2, k3;
  logic [WORD_W-1:0] v0, v1, v0_new, v1_new;

  assign k0 = key[127:96];
  assign k1 = key[95:64];
  assign k2 = key[63:32];
  assign k3 = key[31:0];
  assign v0 = data[63:32];
  assign v1 = data[31:0];

  // One full decrypt round; the second half consumes the updated v1.
  always_comb begin
    v1_new = v1 - ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
    v0_new = v0 - ((((v1_new << 4) + k0) ^ (v1_new + sum)) ^ ((v1_new >> 5) + k1));
  end

  // Control FSM, datapath and registered outputs.
  // Outputs trail the state by one cycle, so the first IDLE cycle after SHIFT
  // still shows the last bit with o_ready low; acceptance is gated on o_ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      key        <= '0;
      data       <= '0;
      sum        <= '0;
      round_cnt  <= '0;
      bit_cnt    <= '0;
      o_tx       <= 1'b0;
      o_tx_valid <= 1'b0;
      o_ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          o_tx       <= 1'b0;
          o_tx_valid <= 1'b0;
          if (!o_ready) begin
            o_ready <= 1'b1;
          end else if (i_calculate) begin
            state     <= ROUND;
            sum       <= SUM_INIT;
            round_cnt <= '0;
            o_ready   <= 1'b0;
          end else if (i_key_update) begin
            key <= {key[KEY_W-2:0], i_rx};
          end else if (i_data_shift) begin
            data <= {data[DATA_W-2:0], i_rx};
          end
        end

        ROUND: begin
          o_tx       <= 1'b0;
          o_tx_valid <= 1'b0;
          data       <= {v0_new, v1_new};
          sum        <= sum - DELTA;
          round_cnt  <= round_cnt + 5'd1;
          if (round_cnt == LAST_ROUND) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end

        SHIFT: begin
          // Index rather than shift so data keeps the plaintext afterwards.
          o_tx       <= data[LAST_BIT - bit_cnt];
          o_tx_valid <= 1'b1;
          bit_cnt    <= bit_cnt + 6'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          o_tx       <= 1'b0;
          o_tx_valid <= 1'b0;
          o_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tea_decrypt.sv
// Self-checking bench for tea_decrypt against a whole-block TEA model.
module tb_tea_decrypt;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_key_update;
  logic i_data_shift;
  logic i_calculate;
  logic i_rx;
  logic o_tx;
  logic o_tx_valid;
  logic o_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] DELTA = 32'h9E37_79B9;
  localparam int LIMIT = 200;

  tea_decrypt dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_key_update (i_key_update),
    .i_data_shift (i_data_shift),
    .i_calculate  (i_calculate),
    .i_rx         (i_rx),
    .o_tx         (o_tx),
    .o_tx_valid   (o_tx_valid),
    .o_ready      (o_ready)
  );

  always #5 i_clk = ~i_clk;

  // Reference TEA cipher on a whole 64-bit block.
  function automatic logic [63:0] tea_enc(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] y, z, s;
    y = blk[63:32];
    z = blk[31:0];
    s = 32'd0;
    for (int r = 0; r < 32; r++) begin
      s = s + DELTA;
      y = y + ((((z << 4) + k[127:96]) ^ (z + s)) ^ ((z >> 5) + k[95:64]));
      z = z + ((((y << 4) + k[63:32]) ^ (y + s)) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] y, z, s;
    y = blk[63:32];
    z = blk[31:0];
    s = DELTA << 5;
    for (int r = 0; r < 32; r++) begin
      z = z - ((((y << 4) + k[63:32]) ^ (y + s)) ^ ((y >> 5) + k[31:0]));
      y = y - ((((z << 4) + k[127:96]) ^ (z + s)) ^ ((z >> 5) + k[95:64]));
      s = s - DELTA;
    end
    return {y, z};
  endfunction

  task automatic load_key(input logic [127:0] k);
    for (int i = 127; i >= 0; i--) begin
      @(negedge i_clk);
      i_key_update = 1'b1;
      i_rx = k[i];
    end
    @(negedge i_clk);
    i_key_update = 1'b0;
    i_rx = 1'b0;
  endtask

  task automatic load_data(input logic [63:0] d, input int junk);
    for (int i = 0; i < junk; i++) begin
      @(negedge i_clk);
      i_data_shift = 1'b1;
      i_rx = 1'($urandom);
    end
    for (int i = 63; i >= 0; i--) begin
      @(negedge i_clk);
      i_data_shift = 1'b1;
      i_rx = d[i];
    end
    @(negedge i_clk);
    i_data_shift = 1'b0;
    i_rx = 1'b0;
  endtask

  // Start one operation and observe it; cycle numbers count from the start edge.
  task automatic do_op(input bit disturb, input bit prio,
                       output logic [63:0] pt, output int first_v,
                       output int n_valid, output int ready_cyc, output int stray);
    int cyc;
    bit done;
    pt = '0; first_v = -1; n_valid = 0; ready_cyc = -1; stray = 0;
    @(negedge i_clk);
    i_calculate = 1'b1;
    if (prio) begin
      i_key_update = 1'b1;
      i_rx = 1'b1;
    end
    @(negedge i_clk);
    i_calculate = 1'b0;
    i_key_update = 1'b0;
    i_rx = 1'b0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < LIMIT) begin
      if (cyc > 0) @(negedge i_clk);
      if (o_tx_valid) begin
        pt = {pt[62:0], o_tx};
        n_valid++;
        if (first_v < 0) first_v = cyc;
      end else if (o_tx !== 1'b0) begin
        stray++;
      end
      if (o_ready === 1'b1) begin
        ready_cyc = cyc;
        done = 1'b1;
      end else if (disturb) begin
        i_key_update = 1'($urandom);
        i_data_shift = 1'($urandom);
        i_calculate  = 1'($urandom);
        i_rx         = 1'($urandom);
      end
      cyc++;
    end
    i_key_update = 1'b0;
    i_data_shift = 1'b0;
    i_calculate = 1'b0;
    i_rx = 1'b0;
    if (!done) begin
      n_fail++;
      $display("FAIL op_timeout: o_ready not seen within %0d cycles", LIMIT);
    end
  endtask

  task automatic check_op(input string name, input bit disturb, input bit prio,
                          input logic [63:0] exp_pt);
    logic [63:0] pt;
    int fv, nv, rc, st;
    do_op(disturb, prio, pt, fv, nv, rc, st);
    n_checks++;
    if (pt !== exp_pt) begin
      n_fail++;
      $display("FAIL %s_plaintext: got %h expected %h", name, pt, exp_pt);
    end
    n_checks++;
    if (fv !== 33) begin
      n_fail++;
      $display("FAIL %s_first_bit: got cycle %0d expected 33", name, fv);
    end
    n_checks++;
    if (nv !== 64) begin
      n_fail++;
      $display("FAIL %s_valid_count: got %0d expected 64", name, nv);
    end
    n_checks++;
    if (rc !== 97) begin
      n_fail++;
      $display("FAIL %s_ready_latency: got cycle %0d expected 97", name, rc);
    end
    n_checks++;
    if (st !== 0) begin
      n_fail++;
      $display("FAIL %s_tx_idle: got %0d nonzero o_tx cycles expected 0", name, st);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    i_key_update = 1'b0;
    i_data_shift = 1'b0;
    i_calculate = 1'b0;
    i_rx = 1'b0;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_ready, o_tx_valid, o_tx} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready/valid/tx=%b expected 100", {o_ready, o_tx_valid, o_tx});
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_known_vector;
    load_key('0);
    load_data(64'h41EA3A0A94BAA940, 0);
    check_op("known", 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_round_trip;
    logic [127:0] k;
    k = 128'h0123456789ABCDEFFEDCBA9876543210;
    load_key(k);
    load_data(tea_enc(64'hDEADBEEFCAFEBABE, k), 3);
    check_op("round_trip", 1'b0, 1'b0, 64'hDEADBEEFCAFEBABE);
  endtask

  task automatic test_random;
    logic [127:0] k;
    logic [63:0] p;
    for (int i = 0; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      load_key(k);
      load_data(tea_enc(p, k), int'($urandom_range(0, 9)));
      check_op("random", 1'b0, 1'b0, p);
    end
  endtask

  task automatic test_busy_immunity;
    logic [127:0] k;
    logic [63:0] p, c;
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom};
    c = tea_enc(p, k);
    load_key(k);
    load_data(c, 0);
    check_op("busy_disturbed", 1'b1, 1'b0, p);
    load_data(c, 0);
    check_op("busy_after", 1'b0, 1'b0, p);
  endtask

  task automatic test_priority;
    logic [127:0] k;
    logic [63:0] p;
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom};
    load_key(k);
    load_data(tea_enc(p, k), 0);
    check_op("priority", 1'b0, 1'b1, p);
  endtask

  task automatic test_back_to_back;
    logic [127:0] k;
    logic [63:0] c;
    logic [127:0] stream;
    int cyc, nv, ready_first, ready_second, ready_cnt;
    bit done;
    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom};
    load_key(k);
    load_data(c, 0);
    stream = '0; nv = 0; ready_first = -1; ready_second = -1; ready_cnt = 0;
    @(negedge i_clk);
    i_calculate = 1'b1;
    @(negedge i_clk);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 2 * LIMIT) begin
      if (cyc > 0) @(negedge i_clk);
      if (o_tx_valid) begin
        stream = {stream[126:0], o_tx};
        nv++;
      end
      if (o_ready === 1'b1) begin
        if (ready_first < 0) begin
          ready_first = cyc;
          ready_cnt++;
        end else if (cyc > ready_first + 1) begin
          ready_second = cyc;
          done = 1'b1;
        end else begin
          ready_cnt++;
        end
      end
      if (cyc == 100) i_calculate = 1'b0;
      cyc++;
    end
    i_calculate = 1'b0;
    n_checks++;
    if (ready_first !== 97) begin
      n_fail++;
      $display("FAIL b2b_first_ready: got cycle %0d expected 97", ready_first);
    end
    n_checks++;
    if (ready_cnt !== 1) begin
      n_fail++;
      $display("FAIL b2b_ready_width: got %0d cycles expected 1", ready_cnt);
    end
    n_checks++;
    if (ready_second !== 195) begin
      n_fail++;
      $display("FAIL b2b_second_ready: got cycle %0d expected 195", ready_second);
    end
    n_checks++;
    if (nv !== 128) begin
      n_fail++;
      $display("FAIL b2b_valid_count: got %0d expected 128", nv);
    end
    n_checks++;
    if (stream !== {tea_dec(c, k), tea_dec(tea_dec(c, k), k)}) begin
      n_fail++;
      $display("FAIL b2b_stream: got %h expected %h", stream,
               {tea_dec(c, k), tea_dec(tea_dec(c, k), k)});
    end
  endtask

  task automatic test_reset_mid(input int abort_cyc);
    int bad;
    load_key({$urandom, $urandom, $urandom, $urandom});
    load_data({$urandom, $urandom}, 0);
    @(negedge i_clk);
    i_calculate = 1'b1;
    @(negedge i_clk);
    i_calculate = 1'b0;
    repeat (abort_cyc) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_ready, o_tx_valid, o_tx} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort%0d_immediate: got ready/valid/tx=%b expected 100",
               abort_cyc, {o_ready, o_tx_valid, o_tx});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bad = 0;
    repeat (110) begin
      @(negedge i_clk);
      if (o_tx_valid !== 1'b0 || o_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort%0d_quiet: got %0d bad cycles expected 0", abort_cyc, bad);
    end
    // Key was cleared by reset, so the all-zero-key vector applies without reloading.
    load_data(64'h41EA3A0A94BAA940, 0);
    check_op("after_abort", 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_round_trip();
    test_random();
    test_busy_immunity();
    test_priority();
    test_back_to_back();
    test_reset_mid(10);
    test_reset_mid(50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tea_decrypt.md
TEA_DECRYPT -- requirements
Module: tea_decrypt

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port i_key_update, input, 1 bit: while high in IDLE, shift i_rx into the 128-bit key register.
REQ-004 SHALL have port i_data_shift, input, 1 bit: while high in IDLE, shift i_rx into the 64-bit ciphertext register.
REQ-005 SHALL have port i_calculate, input, 1 bit: single-cycle start pulse for decryption.
REQ-006 SHALL have port i_rx, input, 1 bit: serial input data, sampled MSB first.
REQ-007 SHALL have port o_tx, output, 1 bit: serial plaintext out, MSB first.
REQ-008 SHALL have port o_tx_valid, output, 1 bit: high on every cycle that o_tx carries a plaintext bit.
REQ-009 SHALL have port o_ready, output, 1 bit: high when in IDLE and accepting key, data and start inputs.

Function
REQ-010 SHALL implement a three-state FSM: IDLE -> ROUND on accepted i_calculate; ROUND -> SHIFT after round 31; SHIFT -> IDLE after bit 63.
REQ-011 Key load SHALL work as follows: in IDLE with i_key_update=1, key <= {key[126:0], i_rx}; k0=key[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
REQ-012 Data load SHALL work as follows: in IDLE with i_data_shift=1 and i_key_update=0, data <= {data[62:0], i_rx}; v0=data[63:32], v1=data[31:0]; no bit counter; the last 64 bits shifted in are the block.
REQ-013 Priority SHALL be i_calculate > i_key_update > i_data_shift; on a start cycle, no key or data shift occurs.
REQ-014 On start, sum SHALL be loaded with 0xC6EF3720 and the round counter (5 bit) with 0.
REQ-015 Each ROUND cycle SHALL perform one full TEA decrypt round, mod 2^32.
REQ-016 First half of the round SHALL compute v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3), with >> logical.
REQ-017 Second half of the round SHALL compute v0 -= ((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1), where v1' is the updated v1.
REQ-018 At the end of each round, sum SHALL be updated as sum -= 0x9E3779B9.
REQ-019 ROUND SHALL last exactly 32 cycles; sum SHALL equal 0 after the last round.
REQ-020 SHIFT SHALL output {v0,v1} MSB first, one bit per cycle, for exactly 64 cycles with o_tx_valid=1; a 6-bit counter wraps 63->0 on exit.
REQ-021 Latency SHALL be: first o_tx bit in the cycle 33 after the start edge; o_ready returns high 97 cycles after the start edge.
REQ-022 o_ready SHALL be 0 in ROUND and SHIFT; i_calculate, i_key_update and i_data_shift SHALL be ignored there (no restart, no key/data corruption).
REQ-023 Outside SHIFT, o_tx and o_tx_valid SHALL be 0.
REQ-024 The key register SHALL persist across operations; the data register SHALL hold the plaintext after SHIFT until reloaded.
REQ-025 i_calculate asserted for multiple cycles SHALL start exactly one operation; after return to IDLE, a still-high i_calculate SHALL start a new one.

Reset
REQ-026 On i_rst_n=0, the block SHALL immediately enter IDLE with key=0, data=0, sum=0, counters=0, o_tx=0, o_tx_valid=0, o_ready=1.
REQ-027 Reset mid-ROUND or mid-SHIFT SHALL abort the operation with no further o_tx_valid pulses; key SHALL also be cleared.
REQ-028 Deassertion of i_rst_n SHALL take effect at the next i_clk edge.

Verification
REQ-029 Known vector: key=0, shift in 0x41EA3A0A94BAA940, pulse i_calculate -> after 32 cycles, 64 valid bits all 0, then o_ready=1.
REQ-030 Round trip: key=0x0123456789ABCDEFFEDCBA9876543210; ciphertext from the golden tea_encrypt model for plaintext 0xDEADBEEFCAFEBABE -> o_tx stream 0xDEADBEEFCAFEBABE.
REQ-031 Busy immunity: toggle i_key_update, i_data_shift and i_calculate during ROUND and SHIFT -> output identical to the undisturbed run; exactly 64 valid bits.
REQ-032 Priority: i_calculate with i_key_update on the same cycle -> key unchanged, decryption starts.
REQ-033 Reset at ROUND cycle 10 -> o_ready=1 and o_tx_valid=0 immediately; a subsequent load with the known vector and start yields the correct plaintext.
REQ-034 Back-to-back: i_calculate held high -> second operation begins the cycle after the first returns to IDLE, with o_ready high for exactly that one cycle.
